// File: rtl/sprite_raster_counter.sv
// Sweeps a SPR_W x SPR_H sprite at a latched origin, presenting on-screen pixels as screen/ROM address pairs.
// Latency: first pixel one edge after start; clipped pixels drop in one cycle and ignore ready; a free-running tick prescaler runs alongside.
module sprite_raster_counter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPR_W    = 40,
  parameter int SPR_H    = 40,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCR_AW   = 15,
  parameter int SPR_AW   = 11,
  parameter int TICK_DIV = 12500000,
  parameter int TICK_W   = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic              ready,
  output logic              valid,
  output logic [X_W-1:0]    px,
  output logic [Y_W-1:0]    py,
  output logic [SCR_AW-1:0] scr_addr,
  output logic [SPR_AW-1:0] spr_addr,
  output logic              busy,
  output logic              done,
  output logic              tick
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(SPR_H - 1);
  localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [X_W-1:0]    ox;
  logic [Y_W-1:0]    oy;
  logic [TICK_W-1:0] cnt;
  logic [X_W:0]      sx;
  logic [Y_W:0]      sy;
  logic              on_screen;
  logic              adv;

  // One extra bit on the sums so origins near the edge clip instead of wrapping.
  assign sx        = {1'b0, ox} + XS'(col);
  assign sy        = {1'b0, oy} + YS'(row);
  assign on_screen = (32'(sx) < 32'(SCREEN_W)) && (32'(sy) < 32'(SCREEN_H));
  assign adv       = !on_screen || ready;

  assign valid    = (state == RUN) && on_screen;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign tick     = (cnt == CNT_LAST);
  assign px       = sx[X_W-1:0];
  assign py       = sy[Y_W-1:0];
  assign scr_addr = SCR_AW'(py) * SCR_AW'(SCREEN_W) + SCR_AW'(px);
  assign spr_addr = SPR_AW'(row) * SPR_AW'(SPR_W) + SPR_AW'(col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      ox    <= '0;
      oy    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ox    <= x0;
            oy    <= y0;
            col   <= '0;
            row   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) state <= DONE;
              else                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_sprite_raster_counter.sv
// Randomized bench: sweeps checked beat-by-beat against a scan-order list of expected on-screen pixels.
module tb_sprite_raster_counter;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  x0 = '0;
  logic [6:0]  y0 = '0;
  logic        valid, busy, done, tick;
  logic [7:0]  px;
  logic [6:0]  py;
  logic [14:0] scr_addr;
  logic [10:0] spr_addr;

  int n_chk = 0;
  int n_pass = 0;
  int tick_e = 0;

  typedef struct {
    int px;
    int py;
    int scr;
    int spr;
  } beat_t;

  always #5 clk = ~clk;

  sprite_raster_counter #(.TICK_DIV(TDIV), .TICK_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .ready(ready),
    .valid(valid), .px(px), .py(py), .scr_addr(scr_addr), .spr_addr(spr_addr),
    .busy(busy), .done(done), .tick(tick)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Edges since reset release; the tick lands on every TDIV-th edge counting from TDIV-1.
  always @(posedge clk or posedge reset) begin
    if (reset) tick_e <= 0;
    else       tick_e <= tick_e + 1;
  end

  always @(negedge clk) chk("tick", 64'(tick), 64'((tick_e % TDIV) == TDIV - 1));

  task automatic sweep(input int x, input int y, input int pct, input bit inj, input int stop_at);
    beat_t q[$];
    beat_t b;
    int cyc, stalls;
    bit hold, fin, hit;
    logic [40:0] hv;
    for (int r = 0; r < 40; r++)
      for (int c = 0; c < 40; c++)
        if (x + c < 160 && y + r < 120) begin
          b.px = x + c; b.py = y + r; b.scr = (y + r) * 160 + x + c; b.spr = r * 40 + c;
          q.push_back(b);
        end
    @(negedge clk);
    x0 = 8'(x); y0 = 7'(y); start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    cyc = 1; stalls = 0; hold = 0; fin = 0; hit = 0; hv = '0;
    while (!fin && !hit && cyc < 8000) begin
      if (hold) chk("hold_stable", {valid, px, py, scr_addr, spr_addr}, {1'b1, hv});
      if (stop_at >= 0 && valid && int'(spr_addr) == stop_at) begin
        hit = 1;
      end else begin
        start = inj && (cyc == 300);
        if (start) begin
          x0 = 8'(x + 77); y0 = 7'(y + 33);
        end
        ready = ($urandom_range(99) < pct);
        hold = 0;
        if (valid) begin
          if (q.size() == 0) begin
            chk("extra_beat", 64'd1, 64'd0);
          end else begin
            b = q[0];
            chk("beat", {px, py, scr_addr, spr_addr},
                {8'(b.px), 7'(b.py), 15'(b.scr), 11'(b.spr)});
            if (ready) void'(q.pop_front());
            else begin
              stalls++; hold = 1; hv = {px, py, scr_addr, spr_addr};
            end
          end
        end
        if (done) begin
          chk("done_cycle", 64'(cyc), 64'(1601 + stalls));
          chk("beats_left", 64'(q.size()), 64'd0);
          chk("valid_in_done", 64'(valid), 64'd0);
          fin = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!hit) begin
      start = 1'b0; ready = 1'b0;
      chk("sweep_finished", 64'(fin), 64'd1);
      chk("idle_after_done", {busy, done}, 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {valid, busy, done, px, py, scr_addr, spr_addr}, 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    sweep(10, 20, 100, 1'b0, -1);    // fully visible
    sweep(150, 100, 100, 1'b0, -1);  // bottom-right clipping
    sweep(0, 0, 60, 1'b1, -1);       // backpressure plus ignored restart

    sweep(0, 0, 100, 1'b0, 500);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_valid", 64'(valid), 64'd0);
    chk("reset_async_busy", 64'(busy), 64'd0);
    chk("reset_async_tick", 64'(tick), 64'd0);
    @(negedge clk);
    reset = 1'b0; ready = 1'b0;
    sweep(0, 0, 100, 1'b0, -1);

    for (int k = 0; k < 3; k++)
      sweep(int'($urandom_range(255)), int'($urandom_range(127)), int'($urandom_range(100, 40)), 1'b0, -1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
